// File: rtl/z80_arb_pkg.sv
// Shared types and default widths for the Z80 / video single-port RAM arbiter.
package z80_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_Z_ISS,
        ARB_Z_CAP,
        ARB_V_ISS,
        ARB_V_CAP
    } arb_state_e;

endpackage

// File: rtl/z80_mem_arbiter_if.sv
// Bus bundle between the Z80 pins, the video fetch port and the sync RAM.
interface z80_mem_arbiter_if
    import z80_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    // Z80 side
    logic              nMREQ;
    logic              nRD;
    logic              nWR;
    logic              nRFSH;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] DOUT;
    logic [DATA_W-1:0] DIN;
    logic              nWAIT;

    // video fetch side
    logic              v_req;
    logic [ADDR_W-1:0] v_addr;
    logic              v_ack;
    logic              v_valid;
    logic [DATA_W-1:0] v_data;

    // RAM side
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  nMREQ, nRD, nWR, nRFSH, A, DOUT, v_req, v_addr, m_rdata,
        output DIN, nWAIT, v_ack, v_valid, v_data, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output nMREQ, nRD, nWR, nRFSH, A, DOUT, v_req, v_addr, m_rdata,
        input  DIN, nWAIT, v_ack, v_valid, v_data, m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating up-counter with synchronous clear; tracks how long video has been refused.
module arb_starve_cnt #(
    parameter int unsigned MAX = 4,
    parameter int unsigned W   = $clog2(MAX + 1)
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/z80_mem_arbiter.sv
// Serialises Z80 memory cycles and video reads onto one sync RAM, stretching the CPU via nWAIT.
module z80_mem_arbiter
    import z80_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned VID_MAX_WAIT = 4
) (
    input  logic             CLK,
    input  logic             nRESET,
    z80_mem_arbiter_if.slave bus
);

    localparam int unsigned STARVE_W = (VID_MAX_WAIT > 0) ? $clog2(VID_MAX_WAIT + 1) : 1;

    arb_state_e          state;
    arb_state_e          stateNext;
    logic                zDone;
    logic                zDoneNext;
    logic                zSet;
    logic                zAct;
    logic                zPend;
    logic                vPend;
    logic                vWins;
    logic                zWins;
    logic [STARVE_W-1:0] starve;
    logic                starveInc;

    logic                mEnNext;
    logic                mWeNext;
    logic [ADDR_W-1:0]   mAddrNext;
    logic [DATA_W-1:0]   mWdataNext;
    logic                vAckNext;
    logic                vValidNext;
    logic [DATA_W-1:0]   vDataNext;
    logic [DATA_W-1:0]   dinNext;

    // Refresh cycles are excluded so they never reach the RAM.
    assign zAct  = !bus.nMREQ && bus.nRFSH && (!bus.nRD || !bus.nWR);
    assign zPend = zAct && !zDone;
    assign vPend = bus.v_req;
    assign vWins = vPend && (!zPend || (starve == STARVE_W'(VID_MAX_WAIT)));
    assign zWins = zPend && !vWins;

    assign bus.nWAIT = !nRESET || !zPend;

    assign starveInc = bus.v_req && !bus.v_ack;

    arb_starve_cnt #(
        .MAX (VID_MAX_WAIT),
        .W   (STARVE_W)
    ) uStarveCnt (
        .CLK    (CLK),
        .nRESET (nRESET),
        .inc    (starveInc),
        .clr    (bus.v_ack),
        .count  (starve)
    );

    always_comb begin
        stateNext  = state;
        zSet       = 1'b0;
        mEnNext    = 1'b0;
        mWeNext    = 1'b0;
        mAddrNext  = bus.m_addr;
        mWdataNext = bus.m_wdata;
        vAckNext   = 1'b0;
        vValidNext = 1'b0;
        vDataNext  = bus.v_data;
        dinNext    = bus.DIN;

        case (state)
            ARB_IDLE: begin
                if (zWins) begin
                    mEnNext    = 1'b1;
                    mWeNext    = !bus.nWR;
                    mAddrNext  = bus.A;
                    mWdataNext = bus.DOUT;
                    stateNext  = ARB_Z_ISS;
                end else if (vWins) begin
                    mEnNext   = 1'b1;
                    mAddrNext = bus.v_addr;
                    vAckNext  = 1'b1;
                    stateNext = ARB_V_ISS;
                end
            end
            ARB_Z_ISS: begin
                if (bus.m_we) begin
                    zSet      = 1'b1;
                    stateNext = ARB_IDLE;
                end else begin
                    stateNext = ARB_Z_CAP;
                end
            end
            ARB_Z_CAP: begin
                dinNext   = bus.m_rdata;
                zSet      = 1'b1;
                stateNext = ARB_IDLE;
            end
            ARB_V_ISS: begin
                stateNext = ARB_V_CAP;
            end
            ARB_V_CAP: begin
                vDataNext  = bus.m_rdata;
                vValidNext = 1'b1;
                stateNext  = ARB_IDLE;
            end
            default: begin
                stateNext = ARB_IDLE;
            end
        endcase

        // Done only survives while the strobes stay asserted; a dropped strobe re-arms.
        zDoneNext = zAct && (zDone || zSet);
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state       <= ARB_IDLE;
            zDone       <= 1'b0;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.v_ack   <= 1'b0;
            bus.v_valid <= 1'b0;
            bus.v_data  <= '0;
            bus.DIN     <= '0;
        end else begin
            state       <= stateNext;
            zDone       <= zDoneNext;
            bus.m_en    <= mEnNext;
            bus.m_we    <= mWeNext;
            bus.m_addr  <= mAddrNext;
            bus.m_wdata <= mWdataNext;
            bus.v_ack   <= vAckNext;
            bus.v_valid <= vValidNext;
            bus.v_data  <= vDataNext;
            bus.DIN     <= dinNext;
        end
    end

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Directed bench for z80_mem_arbiter with a behavioural sync RAM behind it.
module tb_z80_mem_arbiter;

    logic CLK;
    logic nRESET;

    z80_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    z80_mem_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .VID_MAX_WAIT (4)
    ) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .bus    (bus)
    );

    logic [7:0] mem [0:65535];
    int nTests;
    int nFail;
    int enCnt;
    int weCnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Sync RAM: read data appears the cycle after m_en.
    always @(posedge CLK) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] = bus.m_wdata;
            else          bus.m_rdata <= mem[bus.m_addr];
        end
    end

    always @(negedge CLK) begin
        if (bus.m_en)             enCnt <= enCnt + 1;
        if (bus.m_en && bus.m_we) weCnt <= weCnt + 1;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic zIdle();
        bus.nMREQ = 1'b1;
        bus.nRD   = 1'b1;
        bus.nWR   = 1'b1;
        bus.nRFSH = 1'b1;
    endtask

    // One Z80 access held for at least 'hold' cycles; reports cycles spent with nWAIT low.
    task automatic zAccess(input logic isWr, input logic [15:0] addr, input logic [7:0] data,
                           input int hold, output int waitCyc);
        int n;
        step();
        bus.A     = addr;
        bus.DOUT  = data;
        bus.nMREQ = 1'b0;
        bus.nRD   = isWr;
        bus.nWR   = !isWr;
        #1;
        waitCyc = 0;
        n = 1;
        while (bus.nWAIT !== 1'b1 && waitCyc < 40) begin
            waitCyc++;
            step();
            #1;
            n++;
        end
        while (n < hold) begin
            step();
            n++;
        end
        step();
        zIdle();
    endtask

    int w, e0, w0, ackCyc, validCyc, highCyc, r3Wait;
    logic lowSeen, dropV, dropZ, ackSeen, r3Done, zOn;
    logic [7:0] vd, din2;

    initial begin
        nTests = 0;
        nFail  = 0;
        enCnt  = 0;
        weCnt  = 0;
        for (int i = 0; i < 65536; i++) mem[16'(i)] = pat(16'(i));
        mem[16'h1234] = 8'hA5;
        zIdle();
        bus.A      = '0;
        bus.DOUT   = '0;
        bus.v_req  = 1'b0;
        bus.v_addr = '0;
        nRESET     = 1'b1;
        #3 nRESET  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        expectEq("rst_m_en",    32'(bus.m_en),    32'h0);
        expectEq("rst_m_we",    32'(bus.m_we),    32'h0);
        expectEq("rst_m_addr",  32'(bus.m_addr),  32'h0);
        expectEq("rst_v_ack",   32'(bus.v_ack),   32'h0);
        expectEq("rst_v_valid", 32'(bus.v_valid), 32'h0);
        expectEq("rst_din",     32'(bus.DIN),     32'h0);
        expectEq("rst_nwait",   32'(bus.nWAIT),   32'h1);
        step();
        nRESET = 1'b1;

        // Z80 read alone
        e0 = enCnt;
        zAccess(1'b0, 16'h1234, 8'h00, 1, w);
        expectEq("rd_wait", 32'(w), 32'd3);
        expectEq("rd_din",  32'(bus.DIN), 32'hA5);
        step();
        expectEq("rd_en_pulses", 32'(enCnt - e0), 32'd1);

        // Held Z80 write must hit RAM exactly once
        e0 = enCnt;
        w0 = weCnt;
        zAccess(1'b1, 16'h8000, 8'h3C, 6, w);
        expectEq("wr_wait", 32'(w), 32'd2);
        step();
        expectEq("wr_we_pulses", 32'(weCnt - w0), 32'd1);
        expectEq("wr_en_pulses", 32'(enCnt - e0), 32'd1);
        expectEq("wr_mem",       32'(mem[16'h8000]), 32'h3C);
        zAccess(1'b0, 16'h8000, 8'h00, 1, w);
        expectEq("wr_readback", 32'(bus.DIN), 32'h3C);

        // Refresh cycle is ignored
        step();
        e0 = enCnt;
        bus.nMREQ = 1'b0;
        bus.nRFSH = 1'b0;
        #1;
        lowSeen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.nWAIT !== 1'b1) lowSeen = 1'b1;
            step();
        end
        zIdle();
        step();
        expectEq("rfsh_nwait_low", 32'(lowSeen), 32'h0);
        expectEq("rfsh_en_pulses", 32'(enCnt - e0), 32'd0);

        // Simultaneous Z80 read and video request: Z80 first
        step();
        bus.A      = 16'h1357;
        bus.nMREQ  = 1'b0;
        bus.nRD    = 1'b0;
        bus.v_addr = 16'h2345;
        bus.v_req  = 1'b1;
        #1;
        ackCyc = -1; validCyc = -1; highCyc = -1;
        dropV = 1'b0; dropZ = 1'b0; vd = '0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                step();
                if (dropV) bus.v_req = 1'b0;
                if (dropZ) zIdle();
                #1;
            end
            if (bus.v_ack === 1'b1 && ackCyc < 0) begin ackCyc = k; dropV = 1'b1; end
            if (bus.nWAIT === 1'b1 && highCyc < 0) begin highCyc = k; dropZ = 1'b1; end
            if (bus.v_valid === 1'b1 && validCyc < 0) begin validCyc = k; vd = bus.v_data; end
        end
        expectEq("sim_nwait_high", 32'(highCyc),  32'd3);
        expectEq("sim_ack_cycle",  32'(ackCyc),   32'd4);
        expectEq("sim_valid_cyc",  32'(validCyc), 32'd6);
        expectEq("sim_v_data",     32'(vd),       32'(pat(16'h2345)));
        expectEq("sim_din",        32'(bus.DIN),  32'(pat(16'h1357)));

        // Starvation: back-to-back Z80 reads keep video waiting until starve saturates
        step();
        e0 = enCnt;
        bus.v_addr = 16'h4444;
        ackCyc = -1; validCyc = -1; r3Wait = 0;
        ackSeen = 1'b0; r3Done = 1'b0; din2 = '0; vd = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            zOn = (k < 2) || (k == 3) || (k == 4) || (k >= 6 && !r3Done);
            bus.A     = (k < 3) ? 16'h0100 : ((k < 6) ? 16'h0200 : 16'h0300);
            bus.nMREQ = !zOn;
            bus.nRD   = !zOn;
            bus.v_req = !ackSeen;
            #1;
            if (bus.v_ack === 1'b1 && ackCyc < 0) begin ackCyc = k; ackSeen = 1'b1; end
            if (k >= 6 && !r3Done) begin
                if (bus.nWAIT === 1'b1) r3Done = 1'b1;
                else                    r3Wait++;
            end
            if (k == 6) din2 = bus.DIN;
            if (bus.v_valid === 1'b1 && validCyc < 0) begin validCyc = k; vd = bus.v_data; end
        end
        zIdle();
        expectEq("stv_din2",       32'(din2),     32'(pat(16'h0200)));
        expectEq("stv_ack_cycle",  32'(ackCyc),   32'd7);
        expectEq("stv_valid_cyc",  32'(validCyc), 32'd9);
        expectEq("stv_v_data",     32'(vd),       32'(pat(16'h4444)));
        expectEq("stv_z3_wait",    32'(r3Wait),   32'd6);
        expectEq("stv_din3",       32'(bus.DIN),  32'(pat(16'h0300)));
        expectEq("stv_en_pulses",  32'(enCnt - e0), 32'd4);

        // Asynchronous reset while a read sits in Z_CAP
        step();
        bus.A     = 16'h0500;
        bus.DOUT  = 8'hEE;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b0;
        step();
        step();
        #1;
        nRESET = 1'b0;
        #1;
        expectEq("mid_m_addr",  32'(bus.m_addr),  32'h0);
        expectEq("mid_m_wdata", 32'(bus.m_wdata), 32'h0);
        expectEq("mid_din",     32'(bus.DIN),     32'h0);
        expectEq("mid_v_data",  32'(bus.v_data),  32'h0);
        expectEq("mid_nwait",   32'(bus.nWAIT),   32'h1);
        step();
        zIdle();
        step();
        nRESET = 1'b1;
        step();
        expectEq("mid_din_hold", 32'(bus.DIN), 32'h0);
        zAccess(1'b0, 16'h0600, 8'h00, 1, w);
        expectEq("mid_rd_wait", 32'(w), 32'd3);
        expectEq("mid_rd_din",  32'(bus.DIN), 32'(pat(16'h0600)));

        // Z80 strobe that drops before it is granted produces no RAM access
        step();
        e0 = enCnt;
        bus.v_addr = 16'h0700;
        bus.v_req  = 1'b1;
        step();
        bus.A     = 16'h0900;
        bus.nMREQ = 1'b0;
        bus.nRD   = 1'b0;
        #1;
        expectEq("drop_nwait_low", 32'(bus.nWAIT), 32'h0);
        step();
        bus.v_req = 1'b0;
        zIdle();
        step();
        #1;
        expectEq("drop_v_valid", 32'(bus.v_valid), 32'h1);
        expectEq("drop_v_data",  32'(bus.v_data),  32'(pat(16'h0700)));
        step();
        step();
        expectEq("drop_en_pulses", 32'(enCnt - e0), 32'd1);
        expectEq("drop_din_hold",  32'(bus.DIN),    32'(pat(16'h0600)));

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
